// File: rtl/dmem_responder.sv
// dmem_responder: serialized word-RAM responder for the CPU data port.
// One request in flight at a time, with programmable wait states ahead of each access.
module dmem_responder #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_we,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   if (WAIT_CYCLES > 15) begin : g_bad_wait
      $error("dmem_responder: WAIT_CYCLES must be in 0..15");
   end
   if (ADDR_WIDTH < 1 || ADDR_WIDTH > 29) begin : g_bad_aw
      $error("dmem_responder: ADDR_WIDTH must be in 1..29");
   end

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  we_q, we_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0]           mem [DEPTH];
   logic [ADDR_WIDTH-1:0] word_idx;
   logic                  addr_err;
   logic                  mem_wr;
   logic [1:0]            addr_lsb_unused;

   assign word_idx        = addr_q[ADDR_WIDTH+1:2];
   assign addr_err        = |addr_q[31:ADDR_WIDTH+2];
   assign addr_lsb_unused = addr_q[1:0];
   // Reset forces state_q out of ACCESS immediately, so an aborted write never commits.
   assign mem_wr          = (state_q == ST_ACCESS) && !addr_err && (we_q != 4'b0000);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               we_d    = req_we;
               wdata_d = req_wdata;
               cnt_d   = WAIT_INIT;
               state_d = (WAIT_CYCLES != 0) ? ST_WAIT : ST_ACCESS;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            err_d   = addr_err;
            rdata_d = (!addr_err && (we_q == 4'b0000)) ? mem[word_idx] : '0;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         we_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // RAM contents survive reset, so this block has no reset branch.
   always_ff @(posedge clk) begin
      if (mem_wr) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (we_q[i]) begin
               mem[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances (WAIT_CYCLES 1, 0, 3, 15) driven in lockstep
// and checked against directed vectors and a byte-level memory model.
module tb_dmem_responder;

   localparam int NI = 4;

   function automatic int unsigned wait_of(input int unsigned g);
      case (g)
         0:       return 1;
         1:       return 0;
         2:       return 3;
         default: return 15;
      endcase
   endfunction

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic [31:0] req_addr;
   logic [3:0]  req_we;
   logic [31:0] req_wdata;
   logic        resp_ready;

   logic        req_ready_v  [NI];
   logic        resp_valid_v [NI];
   logic [31:0] resp_rdata_v [NI];
   logic        resp_err_v   [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      dmem_responder #(
         .ADDR_WIDTH  (10),
         .WAIT_CYCLES (wait_of(g))
      ) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .req_valid  (req_valid),
         .req_ready  (req_ready_v[g]),
         .req_addr   (req_addr),
         .req_we     (req_we),
         .req_wdata  (req_wdata),
         .resp_valid (resp_valid_v[g]),
         .resp_ready (resp_ready),
         .resp_rdata (resp_rdata_v[g]),
         .resp_err   (resp_err_v[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int unsigned tests = 0;
   int unsigned fails = 0;

   // Reference memory: per instance, bytes plus a per-lane "has been written" mask.
   logic [31:0] ref_mem   [NI][1024];
   logic [3:0]  ref_known [NI][1024];

   logic [31:0] got_rdata [NI];
   logic        got_err   [NI];
   logic [31:0] vld       [NI];
   logic [31:0] rdy       [NI];

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input int unsigned inst,
                        input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s [WAIT_CYCLES=%0d]: got %h, expected %h", name, wait_of(inst), act, exp);
      end
   endtask

   function automatic bit all_ready();
      bit r;
      r = 1'b1;
      for (int i = 0; i < NI; i++) r = r && (req_ready_v[i] === 1'b1);
      return r;
   endfunction

   task automatic model_write(input int unsigned i, input logic [31:0] a,
                              input logic [3:0] we, input logic [31:0] d);
      logic [9:0] idx;
      idx = a[11:2];
      if (a >= 32'h0000_1000) return;
      for (int l = 0; l < 4; l++) begin
         if (we[l]) begin
            ref_mem[i][idx][8*l +: 8] = d[8*l +: 8];
            ref_known[i][idx][l]      = 1'b1;
         end
      end
   endtask

   function automatic logic [31:0] exp_data(input int unsigned i, input logic [31:0] a,
                                            input logic [3:0] we);
      logic [9:0] idx;
      idx = a[11:2];
      if (a >= 32'h0000_1000 || we != 4'b0000) return '0;
      return ref_mem[i][idx];
   endfunction

   function automatic logic [31:0] exp_mask(input int unsigned i, input logic [31:0] a,
                                            input logic [3:0] we);
      logic [9:0] idx;
      logic [3:0] k;
      idx = a[11:2];
      if (a >= 32'h0000_1000 || we != 4'b0000) return '1;
      k = ref_known[i][idx];
      return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
   endfunction

   task automatic wait_idle();
      int unsigned n;
      n = 0;
      @(negedge clk);
      while (!all_ready() && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("idle_before_request", 0, 32'(all_ready()), 32'd1);
   endtask

   // One transaction with resp_ready held high; records per-cycle valid/ready for cycles 1..20.
   task automatic run_txn(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
      logic seen [NI];
      int unsigned w;
      wait_idle();
      req_valid = 1'b1;
      req_addr  = a;
      req_we    = we;
      req_wdata = d;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_we    = 4'($urandom_range(0, 15));
      req_wdata = $urandom;
      for (int i = 0; i < NI; i++) begin
         vld[i] = '0;
         rdy[i] = '0;
         seen[i] = 1'b0;
         got_rdata[i] = '0;
         got_err[i] = 1'b0;
      end
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            vld[i][c] = resp_valid_v[i];
            rdy[i][c] = req_ready_v[i];
            if (resp_valid_v[i] === 1'b1 && !seen[i]) begin
               seen[i]      = 1'b1;
               got_rdata[i] = resp_rdata_v[i];
               got_err[i]   = resp_err_v[i];
            end
         end
      end
      for (int i = 0; i < NI; i++) begin
         w = wait_of(i);
         check("resp_valid_cycles", i, vld[i], 32'd1 << (w + 2));
         check("req_ready_cycles", i, rdy[i], 32'h001F_FFFE & ~((32'd1 << (w + 3)) - 32'd1));
         model_write(i, a, we, d);
      end
   endtask

   logic [31:0] a;
   logic [3:0]  we;
   logic [31:0] d;
   logic [31:0] pd [NI];
   logic [31:0] pm [NI];
   logic        pe;
   logic        stable [NI];

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_addr   = '0;
      req_we     = '0;
      req_wdata  = '0;
      resp_ready = 1'b1;
      for (int i = 0; i < NI; i++)
         for (int j = 0; j < 1024; j++) begin
            ref_known[i][j] = '0;
            ref_mem[i][j]   = '0;
         end

      vecs[0]  = '{"sw_10_full",      32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
      vecs[1]  = '{"lw_10",           32'h0000_0010, 4'b0000, 32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[2]  = '{"sw_40_base",      32'h0000_0040, 4'b1111, 32'h1122_3344, 32'h0000_0000, 1'b0};
      vecs[3]  = '{"sw_40_lane2",     32'h0000_0040, 4'b0100, 32'hAAAA_AAAA, 32'h0000_0000, 1'b0};
      vecs[4]  = '{"lw_40_merge1",    32'h0000_0040, 4'b0000, 32'h0,         32'h11AA_3344, 1'b0};
      vecs[5]  = '{"sw_40_lanes32",   32'h0000_0040, 4'b1100, 32'hBBBB_BBBB, 32'h0000_0000, 1'b0};
      vecs[6]  = '{"lw_40_merge2",    32'h0000_0040, 4'b0000, 32'h0,         32'hBBBB_3344, 1'b0};
      vecs[7]  = '{"sw_0_full",       32'h0000_0000, 4'b1111, 32'h0102_0304, 32'h0000_0000, 1'b0};
      vecs[8]  = '{"sw_1000_oor",     32'h0000_1000, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
      vecs[9]  = '{"lw_0_unchanged",  32'h0000_0000, 4'b0000, 32'h0,         32'h0102_0304, 1'b0};
      vecs[10] = '{"lw_2000_oor",     32'h0000_2000, 4'b0000, 32'h0,         32'h0000_0000, 1'b1};
      vecs[11] = '{"lw_13_lowbits",   32'h0000_0013, 4'b0000, 32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[12] = '{"sw_3fc_clear",    32'h0000_03FC, 4'b1111, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[13] = '{"sw_3fe_lanes20",  32'h0000_03FE, 4'b0101, 32'h9988_7766, 32'h0000_0000, 1'b0};
      vecs[14] = '{"lw_3fc_sparse",   32'h0000_03FC, 4'b0000, 32'h0,         32'h0088_0066, 1'b0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         check("reset_req_ready",  i, 32'(req_ready_v[i]),  32'd1);
         check("reset_resp_valid", i, 32'(resp_valid_v[i]), 32'd0);
         check("reset_resp_rdata", i, resp_rdata_v[i],      32'd0);
         check("reset_resp_err",   i, 32'(resp_err_v[i]),   32'd0);
      end
      rst_n = 1'b1;

      for (int v = 0; v < 15; v++) begin
         run_txn(vecs[v].addr, vecs[v].we, vecs[v].wdata);
         for (int i = 0; i < NI; i++) begin
            check({vecs[v].name, "_rdata"}, i, got_rdata[i], vecs[v].exp_rdata);
            check({vecs[v].name, "_err"},   i, 32'(got_err[i]), 32'(vecs[v].exp_err));
         end
      end

      // Reset pulse in cycle 2 of a write: only the zero-wait instance has passed ACCESS.
      run_txn(32'h0000_0020, 4'b1111, 32'h1234_5678);
      wait_idle();
      req_valid = 1'b1;
      req_addr  = 32'h0000_0020;
      req_we    = 4'b1111;
      req_wdata = 32'hCAFE_F00D;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) begin
         check("midop_reset_req_ready",  i, 32'(req_ready_v[i]),  32'd1);
         check("midop_reset_resp_valid", i, 32'(resp_valid_v[i]), 32'd0);
         check("midop_reset_resp_rdata", i, resp_rdata_v[i],      32'd0);
         check("midop_reset_resp_err",   i, 32'(resp_err_v[i]),   32'd0);
      end
      #1 rst_n = 1'b1;
      for (int i = 0; i < NI; i++)
         if (wait_of(i) == 0) model_write(i, 32'h0000_0020, 4'b1111, 32'hCAFE_F00D);
      run_txn(32'h0000_0020, 4'b0000, 32'h0);
      for (int i = 0; i < NI; i++)
         check("midop_reset_readback", i, got_rdata[i],
               (wait_of(i) == 0) ? 32'hCAFE_F00D : 32'h1234_5678);

      // Backpressure: response held for 10 cycles after the slowest instance reaches RESP.
      run_txn(32'h0000_0044, 4'b1111, 32'h5A5A_1234);
      wait_idle();
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_addr   = 32'h0000_0044;
      req_we     = 4'b0000;
      @(posedge clk);
      #1 req_valid = 1'b0;
      req_addr = 32'h0000_0010;
      repeat (17) @(negedge clk);
      for (int i = 0; i < NI; i++) stable[i] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         for (int i = 0; i < NI; i++)
            if (resp_valid_v[i] !== 1'b1 || req_ready_v[i] !== 1'b0 ||
                resp_rdata_v[i] !== 32'h5A5A_1234 || resp_err_v[i] !== 1'b0)
               stable[i] = 1'b0;
      end
      for (int i = 0; i < NI; i++) check("backpressure_hold", i, 32'(stable[i]), 32'd1);
      @(posedge clk);
      #1 resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         check("backpressure_release_ready", i, 32'(req_ready_v[i]),  32'd1);
         check("backpressure_release_valid", i, 32'(resp_valid_v[i]), 32'd0);
      end

      for (int t = 0; t < 60; t++) begin
         a = {26'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         if ($urandom_range(0, 7) == 0) a[31:12] = 20'($urandom_range(1, 20'hFFFFF));
         we = ($urandom_range(0, 1) == 1) ? 4'b0000 : 4'($urandom_range(0, 15));
         d  = $urandom;
         pe = (a >= 32'h0000_1000);
         for (int i = 0; i < NI; i++) begin
            pd[i] = exp_data(i, a, we);
            pm[i] = exp_mask(i, a, we);
         end
         run_txn(a, we, d);
         for (int i = 0; i < NI; i++) begin
            check("rand_err", i, 32'(got_err[i]), 32'(pe));
            if (pm[i] != 32'h0) check("rand_rdata", i, got_rdata[i] & pm[i], pd[i] & pm[i]);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the CPU data port. It accepts one word-aligned request at a time carrying a 4-bit byte-lane write enable and lane-replicated write data, as produced by the CPU's load/store wrapper. It performs the access on an internal word RAM after a programmable number of wait states and returns the raw 32-bit word over a valid/ready response handshake. Sign extension and lane selection for loads stay on the CPU side; this block only stores and returns whole words.

## Interface
Parameters:
- ADDR_WIDTH, 10: word-address bits; RAM depth = 2^ADDR_WIDTH words.
- WAIT_CYCLES, 1: wait states inserted before each access; legal range 0..15.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address; bits [1:0] ignored; word index = req_addr[ADDR_WIDTH+1:2].
- req_we  in  4  byte-lane write enables; 4'b0000 = read.
- req_wdata  in  32  write data; lane i = bits [8i+7:8i].
- resp_valid  out  1  response present.
- resp_ready  in  1  CPU accepts the response.
- resp_rdata  out  32  read word; 0 for writes and errors.
- resp_err  out  1  address out of range.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid=1, capture addr, we and wdata, and load the wait counter with WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else go to ACCESS.
- WAIT: req_ready=0. The counter decrements each cycle. Move to ACCESS on the cycle the counter reads 1.
- ACCESS: one cycle.
  - Range check: error if req_addr[31:ADDR_WIDTH+2] is nonzero.
  - If there is no error and we≠0, write each lane i with we[i]=1 at the clock edge; other lanes keep their value.
  - If there is no error and we=0, register the stored word into resp_rdata.
  - Set resp_err accordingly. Go to RESP.
- RESP: resp_valid=1, and resp_rdata/resp_err are held stable. When resp_valid && resp_ready, go to IDLE. resp_ready is ignored in other states.
- Error access: no RAM lanes change, resp_rdata=0, resp_err=1.
- Write response: resp_rdata=0, resp_err=0.
- Any req_we pattern is legal, including non-contiguous lanes. The block does not check alignment.
- Request inputs are sampled only in the IDLE handshake cycle. Changes on them afterwards have no effect.
- RAM contents are not cleared by reset.

## Timing
- Reset (asynchronous assert, removal synchronous to clk): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, counter=0, captured registers=0.
- Cycle numbering: the request handshake is cycle 0.
  - Cycles 1..WAIT_CYCLES are WAIT.
  - Cycle WAIT_CYCLES+1 is ACCESS.
  - resp_valid is first high in cycle WAIT_CYCLES+2.
  - Minimum latency with WAIT_CYCLES=0: resp_valid in cycle 2.
- A response handshake in cycle N makes req_ready=1 in cycle N+1. There is no request/response overlap, and the peak rate is one request every WAIT_CYCLES+3 cycles.
- Backpressure: resp_ready low holds RESP indefinitely, with outputs unchanged.
- Reset during WAIT or ACCESS before the ACCESS clock edge: the write is not committed. Reset during RESP: the response is dropped. In both cases the block is in IDLE afterwards.
- A read following a write to the same word returns the written data. There are no hazards because accesses are serialized.

## Test plan
- Write then read, WAIT_CYCLES=1: sw addr 0x10, we=1111, wdata 0xDEADBEEF. Then lw addr 0x10 → resp_rdata 0xDEADBEEF, resp_err=0; resp_valid first high in cycle 3 after each handshake.
- Byte merge: memory word 0x11223344. Write we=0100, wdata 0xAAAAAAAA, then read → 0x11AA3344. Then write we=1100, wdata 0xBBBBBBBB → read 0xBBBB3344.
- Latency sweep: WAIT_CYCLES=0, 3, 15 → resp_valid first high in cycles 2, 5, 17 respectively; req_ready low from cycle 1 until the response handshake.
- Backpressure: hold resp_ready=0 for 10 cycles → resp_valid and resp_rdata stable and req_ready=0 throughout. Raise resp_ready → req_ready=1 on the next cycle.
- Out of range, ADDR_WIDTH=10: write to 0x1000 with we=1111 → resp_err=1, resp_rdata=0. A following read of 0x0000 returns unchanged contents.
- Reset mid-op, WAIT_CYCLES=3: write 0xCAFEF00D to 0x20, pulse rst_n low in cycle 2 → all outputs at reset values. A subsequent read of 0x20 returns the old contents.
